// File: rtl/rr_arbiter4_pkg.sv
// rtl/rr_arbiter4_pkg.sv - shared constants, types and helpers for the 4-way round-robin arbiter
package rr_arbiter4_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [NREQ-1:0]  vec_t;

  function automatic vec_t onehot(input idx_t idx);
    vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick: first set request after last, wrapping 3->0
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       valid
);

  idx_t cand;

  // Walk from the farthest candidate (last itself) to the nearest so the nearest set bit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last + idx_t'(k);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - round-robin arbiter with grant hold, abort and watchdog release
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam cnt_t WD_LAST = cnt_t'(TIMEOUT_CYC - 1);

  logic state_q, state_d;
  vec_t gnt_q, gnt_d;
  idx_t sel_q, sel_d;
  idx_t last_q, last_d;
  cnt_t cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic tout_q, tout_d;

  idx_t pick_idx;
  logic pick_valid;
  logic granted;
  logic wd_hit;
  logic rel;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign granted = (state_q == ST_GRANT);
  assign wd_hit  = granted && (cnt_q == WD_LAST);
  // last_q always holds the current owner while granted.
  assign rel     = granted && (done || !req[last_q] || wd_hit);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    busy_d  = busy_q;
    tout_d  = granted && wd_hit && !done;
    cnt_d   = (granted && (cnt_q != '1)) ? cnt_q + cnt_t'(1) : cnt_q;

    if ((!granted || rel) && pick_valid) begin
      state_d = ST_GRANT;
      gnt_d   = onehot(pick_idx);
      sel_d   = pick_idx;
      last_d  = pick_idx;
      busy_d  = 1'b1;
      cnt_d   = '0;
    end else if (rel) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = tout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - directed and random checks of rr_arbiter4 against a behavioural model
module tb_rr_arbiter4;

  localparam int TO = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  int m_owner;
  int m_last;
  int m_sel;
  int m_cnt;
  int m_tout;

  rr_arbiter4 #(.TIMEOUT_CYC(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic int winner(input logic [3:0] r, input int l);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (l + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_cnt   = 0;
    m_tout  = 0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_last  = w;
    m_sel   = w;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int w;
    bit wd;
    bit rl;
    m_tout = 0;
    if (m_owner < 0) begin
      w = winner(r, m_last);
      if (w >= 0) model_grant(w);
    end else begin
      wd = (m_cnt == TO - 1);
      rl = d || !r[m_owner] || wd;
      if (wd && !d) m_tout = 1;
      if (rl) begin
        w = winner(r, m_owner);
        if (w >= 0) model_grant(w);
        else m_owner = -1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".gnt"},     int'(gnt),     (m_owner < 0) ? 0 : (1 << m_owner));
    chk({tag, ".sel"},     int'(sel),     m_sel);
    chk({tag, ".busy"},    int'(busy),    (m_owner < 0) ? 0 : 1);
    chk({tag, ".timeout"}, int'(timeout), m_tout);
  endtask

  task automatic cycle(input string tag, input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  initial begin
    logic [3:0] r;
    logic       d;

    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_model("reset");
    reset = 1'b0;

    // single requester
    cycle("single.c1", 4'b0001, 1'b0);
    chk("single.gnt_c1", int'(gnt), 1);
    cycle("single.c2", 4'b0001, 1'b0);
    cycle("single.c3", 4'b0001, 1'b0);
    cycle("single.c4", 4'b0000, 1'b1);
    chk("single.busy_c4", int'(busy), 0);
    chk("single.sel_c4", int'(sel), 0);
    cycle("single.done_idle", 4'b0000, 1'b1);

    // full rotation with done every cycle
    for (int i = 0; i < 8; i++) cycle("rot", 4'b1111, 1'b1);
    cycle("rot.end", 4'b0000, 1'b1);

    // wrap / skip
    cycle("wrap.g1", 4'b0010, 1'b0);
    chk("wrap.sel1", int'(sel), 1);
    cycle("wrap.g3", 4'b1010, 1'b1);
    chk("wrap.sel3", int'(sel), 3);
    cycle("wrap.g1b", 4'b1010, 1'b1);
    chk("wrap.sel1b", int'(sel), 1);
    cycle("wrap.end", 4'b0000, 1'b1);

    // watchdog
    cycle("wd.grant", 4'b0100, 1'b0);
    for (int i = 0; i < TO - 1; i++) cycle("wd.hold", 4'b0100, 1'b0);
    cycle("wd.fire", 4'b0100, 1'b0);
    chk("wd.timeout", int'(timeout), 1);
    chk("wd.regrant", int'(gnt), 4);
    cycle("wd.after", 4'b0100, 1'b0);
    chk("wd.pulse_end", int'(timeout), 0);
    for (int i = 0; i < TO - 2; i++) cycle("wd.hold2", 4'b0100, 1'b0);
    cycle("wd.done_wins", 4'b0100, 1'b1);
    chk("wd.done_no_timeout", int'(timeout), 0);
    cycle("wd.end", 4'b0000, 1'b1);

    // abort
    cycle("abort.g0", 4'b0001, 1'b0);
    cycle("abort.switch", 4'b0010, 1'b0);
    chk("abort.gnt", int'(gnt), 2);
    chk("abort.timeout", int'(timeout), 0);
    cycle("abort.done_and_abort", 4'b1000, 1'b1);
    cycle("abort.g3", 4'b1000, 1'b0);

    // asynchronous reset mid-grant
    chk("rst.pre_gnt", int'(gnt), 8);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst.async_gnt", int'(gnt), 0);
    chk("rst.async_sel", int'(sel), 0);
    chk("rst.async_busy", int'(busy), 0);
    #1;
    reset = 1'b0;
    cycle("rst.after", 4'b1001, 1'b0);
    chk("rst.first_is_0", int'(gnt), 1);
    cycle("rst.done", 4'b1001, 1'b1);
    chk("rst.then_3", int'(gnt), 8);

    // random
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      d = ($urandom_range(0, 5) == 0);
      cycle("rand", r, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
